// File: rtl/score_pkg.sv
// score_pkg
// Shared constants for the score timer slice.
//   ST_IDLE / ST_RUN / ST_OVER : encoding of the game state output
//   MAX_TIME_DEFAULT           : seconds saturation value (99:59)
package score_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_OVER = 2'd2;

  localparam int unsigned MAX_TIME_DEFAULT = 5999;

endpackage

// File: rtl/tick_divider.sv
// tick_divider
// Free-running modulo-DIV counter that pulses tick_o for one cycle on its
// terminal count (DIV-1).
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clr_i : synchronous clear back to count 0
//   en_i  : count enable; the tick is only produced while enabled
//   tick_o: one-cycle pulse on the terminal count
module tick_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         atLast;

  // The terminal count doubles as the wrap condition, so a DIV=1 divider
  // simply ticks on every enabled cycle.
  always_comb begin
    atLast = (cnt_q == LAST);
    tick_o = en_i && atLast;
    cnt_d  = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = atLast ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register; reset and clear both return it to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/score_timer_ctrl.sv
// score_timer_ctrl
// Game-level controller for the MM:SS display path: sequences IDLE/RUN/OVER,
// counts seconds alive, keeps the best time, drives the display value,
// game-over blink blanking and the digit-refresh clock.
//   clk, rst   : system clock, synchronous active-high reset
//   start      : one-cycle pulse, begin a new game
//   alive      : level, player alive
//   show_best  : level, display best time (ignored in RUN)
//   disp_value : registered seconds value for the display
//   best       : best time so far in seconds
//   blank      : registered display blanking (2 Hz blink in OVER)
//   segclk     : registered square wave at SEG_HZ
//   state      : 0 IDLE, 1 RUN, 2 OVER
module score_timer_ctrl
  import score_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SEG_HZ   = 1000,
  parameter int unsigned MAX_TIME = MAX_TIME_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        alive,
  input  logic        show_best,
  output logic [15:0] disp_value,
  output logic [15:0] best,
  output logic        blank,
  output logic        segclk,
  output logic [1:0]  state
);

  localparam int unsigned SEC_DIV   = (CLK_HZ > 0) ? CLK_HZ : 1;
  localparam int unsigned BLINK_DIV = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam int unsigned HALF_DIV  = (CLK_HZ / (2 * SEG_HZ) > 0) ? CLK_HZ / (2 * SEG_HZ) : 1;
  localparam logic [15:0] MAX16     = 16'(MAX_TIME);

  logic [1:0]  state_q, state_d;
  logic [15:0] timeAlive_q, timeAlive_d;
  logic [15:0] best_q, best_d;
  logic [15:0] dispValue_q, dispValue_d;
  logic        blank_q, blank_d;
  logic        segClk_q, segClk_d;

  logic secTick, blinkTick, segTick;
  logic inRun, inOver;

  assign inRun  = (state_q == ST_RUN);
  assign inOver = (state_q == ST_OVER);

  // The seconds prescaler is held clear outside RUN so every game starts a
  // full second away from its first increment.
  tick_divider #(.DIV(SEC_DIV)) uSecDiv (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!inRun),
    .en_i   (inRun),
    .tick_o (secTick)
  );

  // The blink prescaler is held clear outside OVER, giving a full-length
  // first unblanked half-period after each game ends.
  tick_divider #(.DIV(BLINK_DIV)) uBlinkDiv (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (!inOver),
    .en_i   (inOver),
    .tick_o (blinkTick)
  );

  // Half-period divider for the refresh clock; runs regardless of state.
  tick_divider #(.DIV(HALF_DIV)) uSegDiv (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (1'b0),
    .en_i   (1'b1),
    .tick_o (segTick)
  );

  // Game state machine, seconds count and best-time update. Losing a life
  // takes priority over a coincident seconds tick so the frozen time is the
  // one the player actually reached.
  always_comb begin
    state_d     = state_q;
    timeAlive_d = timeAlive_q;
    best_d      = best_q;
    blank_d     = blank_q;
    case (state_q)
      ST_IDLE: begin
        timeAlive_d = '0;
        blank_d     = 1'b0;
        if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        blank_d = 1'b0;
        if (!alive) begin
          state_d = ST_OVER;
          best_d  = (timeAlive_q > best_q) ? timeAlive_q : best_q;
        end else if (secTick && (timeAlive_q < MAX16)) begin
          timeAlive_d = timeAlive_q + 16'd1;
        end
      end
      ST_OVER: begin
        if (start) begin
          state_d     = ST_RUN;
          timeAlive_d = '0;
          blank_d     = 1'b0;
        end else if (blinkTick) begin
          blank_d = !blank_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        timeAlive_d = '0;
        blank_d     = 1'b0;
      end
    endcase
  end

  // Display selection works from the current registered values, so the
  // display lags the state and count by one cycle.
  always_comb begin
    dispValue_d = (!inRun && show_best) ? best_q : timeAlive_q;
    segClk_d    = segTick ? !segClk_q : segClk_q;
  end

  // All controller registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timeAlive_q <= '0;
      best_q      <= '0;
      dispValue_q <= '0;
      blank_q     <= 1'b0;
      segClk_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timeAlive_q <= timeAlive_d;
      best_q      <= best_d;
      dispValue_q <= dispValue_d;
      blank_q     <= blank_d;
      segClk_q    <= segClk_d;
    end
  end

  assign disp_value = dispValue_q;
  assign best       = best_q;
  assign blank      = blank_q;
  assign segclk     = segClk_q;
  assign state      = state_q;

endmodule

// File: tb/tb_score_timer_ctrl.sv
// tb_score_timer_ctrl
// Self-checking bench for score_timer_ctrl with CLK_HZ=8, SEG_HZ=2,
// MAX_TIME=5. A cycle-count model predicts every output; directed scenarios
// pin literal values, then a randomized phase exercises the rest.
module tb_score_timer_ctrl;

  localparam int CLK_HZ   = 8;
  localparam int SEG_HZ   = 2;
  localparam int MAX_TIME = 5;
  localparam int HALF     = CLK_HZ / (2 * SEG_HZ);
  localparam int BLINK    = CLK_HZ / 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        alive = 1'b1;
  logic        show_best = 1'b0;
  logic [15:0] disp_value;
  logic [15:0] best;
  logic        blank;
  logic        segclk;
  logic [1:0]  state;

  int checks = 0;
  int failures = 0;

  int mState = 0;
  int mTime = 0;
  int mBest = 0;
  int mDisp = 0;
  int mBlank = 0;
  int mSeg = 0;
  int runEdges = 0;
  int overEdges = 0;
  int segEdges = 0;
  bit modelValid = 1'b0;

  score_timer_ctrl #(
    .CLK_HZ   (CLK_HZ),
    .SEG_HZ   (SEG_HZ),
    .MAX_TIME (MAX_TIME)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .alive      (alive),
    .show_best  (show_best),
    .disp_value (disp_value),
    .best       (best),
    .blank      (blank),
    .segclk     (segclk),
    .state      (state)
  );

  // 10 time-unit clock period.
  always #5 clk = ~clk;

  // Compares one DUT value against its expectation and tallies the result.
  task automatic checkOutput(input string name, input logic [15:0] act, input int expv);
    checks++;
    if (act !== 16'(expv)) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at t=%0t", name, act, expv, $time);
    end
  endtask

  // Drives all inputs for the next clock edge, then waits one cycle.
  task automatic applyStimulus(input logic r, input logic s, input logic a, input logic sb);
    rst       = r;
    start     = s;
    alive     = a;
    show_best = sb;
    @(negedge clk);
  endtask

  // Behavioural model: time alive is whole seconds elapsed in RUN, blanking
  // and segclk are square waves derived from edges elapsed since their origin.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mState = 0; mTime = 0; mBest = 0; mDisp = 0; mBlank = 0; mSeg = 0;
        runEdges = 0; overEdges = 0; segEdges = 0;
        modelValid = 1'b1;
      end else begin
        int newDisp;
        newDisp = (mState != 1 && show_best) ? mBest : mTime;
        segEdges++;
        mSeg = (segEdges / HALF) % 2;
        if (mState == 0) begin
          if (start) begin
            mState = 1; runEdges = 0; mTime = 0;
          end
        end else if (mState == 1) begin
          if (!alive) begin
            if (mTime > mBest) mBest = mTime;
            mState = 2; overEdges = 0; mBlank = 0;
          end else begin
            runEdges++;
            mTime = (runEdges / CLK_HZ > MAX_TIME) ? MAX_TIME : runEdges / CLK_HZ;
          end
        end else begin
          if (start) begin
            mState = 1; runEdges = 0; mTime = 0; mBlank = 0;
          end else begin
            overEdges++;
            mBlank = (overEdges / BLINK) % 2;
          end
        end
        mDisp = newDisp;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (modelValid) begin
        checkOutput("model_state", 16'(state), mState);
        checkOutput("model_disp", disp_value, mDisp);
        checkOutput("model_best", best, mBest);
        checkOutput("model_blank", 16'(blank), mBlank);
        checkOutput("model_segclk", 16'(segclk), mSeg);
      end
    end
  end

  // Directed scenarios with hand-computed values, then randomized traffic.
  initial begin
    logic [5:0] blinkSeq;
    blinkSeq = 6'b001100;

    // Reset held for three cycles.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("rst_state", 16'(state), 0);
    checkOutput("rst_disp", disp_value, 0);
    checkOutput("rst_best", best, 0);
    checkOutput("rst_blank", 16'(blank), 0);
    checkOutput("rst_segclk", 16'(segclk), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("seg_first_low", 16'(segclk), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("seg_first_high", 16'(segclk), 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("seg_second_low", 16'(segclk), 0);

    // Run for three seconds; show_best must not affect the RUN display.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (25) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("run_state", 16'(state), 1);
    checkOutput("run_disp3", disp_value, 3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("run_showbest_disp", disp_value, 3);

    // Saturation at MAX_TIME.
    repeat (40) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_disp", disp_value, 5);
    repeat (16) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_hold_disp", disp_value, 5);

    // Fresh game; alive drops on the terminal count at timealive=2.
    repeat (2) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (23) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("coinc_state", 16'(state), 2);
    checkOutput("coinc_disp", disp_value, 2);
    checkOutput("coinc_best", best, 2);

    // OVER blinking pattern, best display, restart and a short second game.
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("blink_%0d", i), 16'(blank), int'(blinkSeq[5 - i]));
      if (i < 5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("over_showbest", disp_value, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("restart_state", 16'(state), 1);
    checkOutput("restart_blank", 16'(blank), 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("restart_disp", disp_value, 0);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("game2_state", 16'(state), 2);
    checkOutput("game2_best", best, 2);
    checkOutput("game2_disp", disp_value, 1);

    // Reset during RUN at timealive=4 clears best as well.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    repeat (33) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_rst_disp", disp_value, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("midrst_state", 16'(state), 0);
    checkOutput("midrst_disp", disp_value, 0);
    checkOutput("midrst_best", best, 0);
    checkOutput("midrst_blank", 16'(blank), 0);

    // Randomized traffic checked by the every-cycle model comparison.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 399) == 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 29) != 0),
                    ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
